canvas_brush_writer: RTL and testbench

//  Write-side counterpart of the VGA scan-out: owns the 40x30 cell canvas write port.

---
 rtl/canvas_brush_writer.sv | 224 ++++++++++++++++++++++
 tb/tb_canvas_brush_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_brush_writer.sv
// canvas_brush_writer
//   Owns the write port of the 40x30 cell canvas read by the VGA scan-out.
//   Moves a brush cursor from push-buttons (with auto-repeat), paints or
//   erases the cell under the cursor, and runs a full-canvas clear sweep.
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   btn_up/down/left/right, clear_req   raw async buttons (active high)
//   paint, erase        switch levels (erase forces BG_COLOR)
//   color[5:0]          brush colour {B,G,R}
//   wr_ready            canvas accepts the presented write this cycle
//   wr_en, wr_x, wr_y, wr_data   write request, held until accepted
//   cursor_x, cursor_y  cursor position for overlay
//   busy                high while a write or clear sweep is in flight
module canvas_brush_writer #(
  parameter int         COLS          = 40,
  parameter int         ROWS          = 30,
  parameter logic [5:0] BG_COLOR      = 6'h00,
  parameter int         REPEAT_DELAY  = 25000000,
  parameter int         REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       paint,
  input  logic       erase,
  input  logic       clear_req,
  input  logic [5:0] color,
  input  logic       wr_ready,
  output logic       wr_en,
  output logic [5:0] wr_x,
  output logic [4:0] wr_y,
  output logic [5:0] wr_data,
  output logic [5:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       busy
);

  localparam logic [5:0] XMAX = 6'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(RMAX + 1);
  localparam logic [CW-1:0] DLY = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER = CW'(REPEAT_PERIOD);

  // bit order: 0 up, 1 down, 2 left, 3 right, 4 clear, 5 paint, 6 erase
  localparam int UP = 0, DN = 1, LF = 2, RT = 3, CLR = 4, PNT = 5, ERS = 6;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_e;

  logic [6:0] raw, s1_q, s2_q;
  logic [5:0] prev_q, press;
  logic [3:0] step;

  assign raw   = {erase, paint, clear_req, btn_right, btn_left, btn_down, btn_up};
  assign press = s2_q[5:0] & ~prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      prev_q <= s2_q[5:0];
    end
  end

  // Per-direction auto-repeat: step on press, again after DLY held cycles,
  // then every PER cycles. Counter restarts at 1 on each step.
  for (genvar g = 0; g < 4; g++) begin : g_rpt
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rep_q, rep_d, hit;

    assign hit     = rep_q ? (cnt_q == PER) : (cnt_q == DLY);
    assign step[g] = s2_q[g] & (press[g] | hit);

    always_comb begin
      cnt_d = cnt_q + CW'(1);
      rep_d = rep_q;
      if (!s2_q[g]) begin
        cnt_d = '0;
        rep_d = 1'b0;
      end else if (press[g]) begin
        cnt_d = CW'(1);
        rep_d = 1'b0;
      end else if (hit) begin
        cnt_d = CW'(1);
        rep_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt_q <= '0;
        rep_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        rep_q <= rep_d;
      end
    end
  end

  state_e     state_q, state_d;
  logic [5:0] cur_x_q, cur_x_d, nx;
  logic [4:0] cur_y_q, cur_y_d, ny;
  logic       wr_en_q, wr_en_d;
  logic [5:0] wr_x_q, wr_x_d, wr_data_q, wr_data_d, col_prev_q, col_prev_d;
  logic [4:0] wr_y_q, wr_y_d;
  logic       clr_pend_q, clr_pend_d;
  logic       moved, trig;

  // Candidate cursor; an axis with both opposing buttons held stays put.
  always_comb begin
    nx = cur_x_q;
    ny = cur_y_q;
    if (step[RT] && !s2_q[LF] && cur_x_q != XMAX)   nx = cur_x_q + 6'd1;
    else if (step[LF] && !s2_q[RT] && cur_x_q != 0) nx = cur_x_q - 6'd1;
    if (step[DN] && !s2_q[UP] && cur_y_q != YMAX)   ny = cur_y_q + 5'd1;
    else if (step[UP] && !s2_q[DN] && cur_y_q != 0) ny = cur_y_q - 5'd1;
  end

  assign moved = (nx != cur_x_q) || (ny != cur_y_q);
  assign trig  = press[PNT] || (s2_q[PNT] && (moved || color != col_prev_q));

  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    wr_en_d    = wr_en_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_data_d  = wr_data_q;
    col_prev_d = col_prev_q;
    clr_pend_d = clr_pend_q;
    case (state_q)
      IDLE: begin
        if (press[CLR]) begin
          state_d   = CLEAR;
          wr_en_d   = 1'b1;
          wr_x_d    = '0;
          wr_y_d    = '0;
          wr_data_d = BG_COLOR;
        end else begin
          cur_x_d    = nx;
          cur_y_d    = ny;
          col_prev_d = color;
          if (trig) begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_x_d    = nx;
            wr_y_d    = ny;
            wr_data_d = s2_q[ERS] ? BG_COLOR : color;
          end
        end
      end
      WRITE: begin
        if (press[CLR]) clr_pend_d = 1'b1;
        if (wr_ready) begin
          if (clr_pend_q || press[CLR]) begin
            state_d    = CLEAR;
            clr_pend_d = 1'b0;
            wr_x_d     = '0;
            wr_y_d     = '0;
            wr_data_d  = BG_COLOR;
          end else begin
            state_d = IDLE;
            wr_en_d = 1'b0;
          end
        end
      end
      CLEAR: begin
        if (wr_ready) begin
          if (wr_x_q == XMAX && wr_y_q == YMAX) begin
            state_d = IDLE;
            wr_en_d = 1'b0;
          end else if (wr_x_q == XMAX) begin
            wr_x_d = '0;
            wr_y_d = wr_y_q + 5'd1;
          end else begin
            wr_x_d = wr_x_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_data_q  <= '0;
      col_prev_q <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_data_q  <= wr_data_d;
      col_prev_q <= col_prev_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;
  assign wr_data  = wr_data_q;
  assign cursor_x = cur_x_q;
  assign cursor_y = cur_y_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_canvas_brush_writer.sv
// Bench for canvas_brush_writer: directed stimulus, scoreboard of expected
// canvas writes checked by an independent monitor on each accepted write.
module tb_canvas_brush_writer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic       paint = 0, erase = 0, clear_req = 0, wr_ready = 0;
  logic [5:0] color = '0;
  logic       wr_en, busy;
  logic [5:0] wr_x, wr_data, cursor_x;
  logic [4:0] wr_y, cursor_y;

  always #5 clk = ~clk;

  canvas_brush_writer #(.REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .paint(paint), .erase(erase), .clear_req(clear_req), .color(color),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
    logic [5:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0, errors = 0;
  int  acc_cnt = 0, en_cycles = 0, busy_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // b: {right, left, down, up}
  task automatic set_btn(input logic [3:0] b);
    {btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    set_btn(b);
    tick(n);
    set_btn(4'b0000);
    tick(5);
  endtask

  task automatic push(input int x, input int y, input int d);
    exp_q.push_back({6'(x), 5'(y), 6'(d)});
  endtask

  // Monitor: every accepted write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en === 1'b1) en_cycles++;
    if (busy === 1'b1) busy_cycles++;
    if (reset_n && wr_en === 1'b1 && wr_ready) begin
      acc_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got (%0d,%0d,%h) expected none", wr_x, wr_y, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({wr_x, wr_y, wr_data} !== mon_e) begin
          errors++;
          $display("FAIL wr_txn: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                   wr_x, wr_y, wr_data, mon_e.x, mon_e.y, mon_e.d);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, b0, a0, n;

    // Reset state
    reset_n = 1'b0;
    tick(3);
    chk("rst_cursor_x", cursor_x, 0);
    chk("rst_cursor_y", cursor_y, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_xyd", {wr_x, wr_y, wr_data}, 0);
    reset_n = 1'b1;
    en_cycles = 0;
    tick(1);

    // Single press: 3-cycle latency, no write without paint
    btn_right = 1'b1;
    tick(2);
    chk("press_lat_x_before", cursor_x, 0);
    tick(1);
    chk("press_lat_x_after", cursor_x, 1);
    btn_right = 1'b0;
    tick(5);
    chk("press_no_write", en_cycles, 0);

    // Auto-repeat: 10 held cycles -> steps at 0, 4, 6, 8
    hold(4'b1000, 10);
    chk("autorepeat_x", cursor_x, 5);

    // Clamping at the far corner and at the origin
    hold(4'b1000, 100);
    hold(4'b0010, 100);
    chk("clamp_far_x", cursor_x, 39);
    chk("clamp_far_y", cursor_y, 29);
    hold(4'b1010, 2);
    chk("clamp_far_press", {cursor_x, cursor_y}, {6'd39, 5'd29});
    hold(4'b0101, 100);
    hold(4'b0101, 2);
    chk("clamp_origin", {cursor_x, cursor_y}, 0);

    // Opposing left+right cancel x, down still moves y
    hold(4'b1110, 2);
    chk("opposing_axis", {cursor_x, cursor_y}, {6'd0, 5'd1});
    hold(4'b0001, 2);
    chk("up_back", cursor_y, 0);

    // Paint: rising edge, move while painting, colour change while painting
    color = 6'h2D;
    tick(2);
    wr_ready = 1'b1;
    push(0, 0, 'h2D);
    paint = 1'b1;
    tick(8);
    chk("paint_rise_done", exp_q.size(), 0);
    chk("paint_wr_en_low", wr_en, 0);
    push(1, 0, 'h2D);
    hold(4'b1000, 2);
    chk("paint_move_done", exp_q.size(), 0);
    chk("paint_move_x", cursor_x, 1);
    push(1, 0, 'h15);
    color = 6'h15;
    tick(4);
    chk("color_change_done", exp_q.size(), 0);
    paint = 1'b0;
    tick(4);

    // Erase with back-pressure at (5,7)
    repeat (4) hold(4'b1000, 2);
    repeat (7) hold(4'b0010, 2);
    chk("pos_5_7", {cursor_x, cursor_y}, {6'd5, 5'd7});
    erase = 1'b1;
    wr_ready = 1'b0;
    tick(3);
    push(5, 7, 0);
    paint = 1'b1;
    n = 0;
    while (wr_en !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    chk("erase_wr_en_seen", wr_en, 1);
    e0 = en_cycles;
    tick(2);
    chk("hold_wr_en", wr_en, 1);
    chk("hold_xyd", {wr_x, wr_y, wr_data}, {6'd5, 5'd7, 6'h00});
    tick(2);
    wr_ready = 1'b1;
    tick(1);
    chk("erase_accept_drop", wr_en, 0);
    chk("erase_en_cycles", en_cycles - e0, 5);
    chk("erase_done", exp_q.size(), 0);
    paint = 1'b0;
    tick(4);
    erase = 1'b0;
    tick(4);

    // Full clear sweep
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++) push(x, y, 0);
    b0 = busy_cycles;
    clear_req = 1'b1;
    tick(2);
    clear_req = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    n = 0;
    while (busy === 1'b1 && n < 1300) begin
      tick(1);
      n++;
    end
    chk("clear_finished", busy, 0);
    chk("clear_busy_cycles", busy_cycles - b0, 1200);
    chk("clear_all_written", exp_q.size(), 0);
    chk("clear_cursor_kept", {cursor_x, cursor_y}, {6'd5, 5'd7});

    // Reset in the middle of a clear sweep
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++) push(x, y, 0);
    a0 = acc_cnt;
    clear_req = 1'b1;
    tick(2);
    clear_req = 1'b0;
    n = 0;
    while (acc_cnt - a0 < 600 && n < 1300) begin
      tick(1);
      n++;
    end
    chk("midclear_reached", acc_cnt - a0, 600);
    reset_n = 1'b0;
    tick(1);
    chk("midclear_wr_en", wr_en, 0);
    chk("midclear_busy", busy, 0);
    chk("midclear_cursor", {cursor_x, cursor_y}, 0);
    chk("midclear_remaining", exp_q.size(), 600);
    exp_q.delete();
    reset_n = 1'b1;
    tick(5);
    chk("post_reset_idle", busy, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
